// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller of the 5-stage MIPS core.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;

   typedef logic [4:0] reg_idx_t;

endpackage : hazard_pkg

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: counts clocks with inc high and sticks at all-ones.
module hazard_sat_counter #(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   output logic [PERF_W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + PERF_W'(1);
      end
   end

endmodule : hazard_sat_counter

// File: rtl/hazard_scoreboard.sv
// Stall/flush/forward control with mul/div HI/LO tracking.
// Optional stall-cycle counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W      = 5,
   parameter int MD_LATENCY = 4,
   parameter int PERF_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [REG_W-1:0]  rs_d_i,
   input  logic [REG_W-1:0]  rt_d_i,
   input  logic              branch_d_i,
   input  logic              md_start_d_i,
   input  logic              md_read_d_i,
   input  logic [REG_W-1:0]  rs_e_i,
   input  logic [REG_W-1:0]  rt_e_i,
   input  logic [REG_W-1:0]  write_reg_e_i,
   input  logic              mem_to_reg_e_i,
   input  logic              reg_write_e_i,
   input  logic              md_start_e_i,
   input  logic [REG_W-1:0]  write_reg_m_i,
   input  logic              mem_to_reg_m_i,
   input  logic              reg_write_m_i,
   input  logic [REG_W-1:0]  write_reg_w_i,
   input  logic              reg_write_w_i,
   output logic              stall_f_o,
   output logic              stall_d_o,
   output logic              flush_e_o,
   output logic              forward_a_d_o,
   output logic              forward_b_d_o,
   output logic [1:0]        forward_a_e_o,
   output logic [1:0]        forward_b_e_o,
   output logic              md_busy_o,
   output logic [PERF_W-1:0] perf_lw_o,
   output logic [PERF_W-1:0] perf_br_o,
   output logic [PERF_W-1:0] perf_md_o
);

   localparam int MD_W = $clog2(MD_LATENCY + 1);

   // Register 0 is hardwired to zero, so it never creates a dependency.
   function automatic logic dep(input logic [REG_W-1:0] src,
                                input logic [REG_W-1:0] dst,
                                input logic             en);
      return (src != '0) && (src == dst) && en;
   endfunction

   logic [MD_W-1:0] md_cnt;
   logic            lw_stall;
   logic            br_stall;
   logic            md_stall;
   logic            stall;
   fwd_sel_e        fwd_a_e;
   fwd_sel_e        fwd_b_e;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      fwd_a_e = FWD_NONE;
      fwd_b_e = FWD_NONE;
      if (dep(rs_e_i, write_reg_m_i, reg_write_m_i))      fwd_a_e = FWD_MEM;
      else if (dep(rs_e_i, write_reg_w_i, reg_write_w_i)) fwd_a_e = FWD_WB;
      if (dep(rt_e_i, write_reg_m_i, reg_write_m_i))      fwd_b_e = FWD_MEM;
      else if (dep(rt_e_i, write_reg_w_i, reg_write_w_i)) fwd_b_e = FWD_WB;
   end

   assign forward_a_e_o = fwd_a_e;
   assign forward_b_e_o = fwd_b_e;
   assign forward_a_d_o = dep(rs_d_i, write_reg_m_i, reg_write_m_i);
   assign forward_b_d_o = dep(rt_d_i, write_reg_m_i, reg_write_m_i);

   assign lw_stall = mem_to_reg_e_i && (rt_e_i != '0) &&
                     ((rs_d_i == rt_e_i) || (rt_d_i == rt_e_i));

   // A branch resolves in D, so it must wait for an ALU result still in E
   // or a load result still in M; ALU results in M are forwarded instead.
   assign br_stall = branch_d_i &&
                     (dep(rs_d_i, write_reg_e_i, reg_write_e_i)  ||
                      dep(rt_d_i, write_reg_e_i, reg_write_e_i)  ||
                      dep(rs_d_i, write_reg_m_i, mem_to_reg_m_i) ||
                      dep(rt_d_i, write_reg_m_i, mem_to_reg_m_i));

   // The issue cycle itself already stalls, before the countdown is loaded.
   assign md_stall = (md_read_d_i || md_start_d_i) && ((md_cnt != '0) || md_start_e_i);

   assign stall     = lw_stall || br_stall || md_stall;
   assign stall_f_o = stall;
   assign stall_d_o = stall;
   assign flush_e_o = stall;
   assign md_busy_o = (md_cnt != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         md_cnt <= '0;
      end else if (md_start_e_i) begin
         md_cnt <= MD_W'(MD_LATENCY);
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - MD_W'(1);
      end
   end

`ifdef HAZARD_PERF_EN
   hazard_sat_counter #(.PERF_W(PERF_W)) u_perf_lw (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (lw_stall),
      .count (perf_lw_o)
   );

   hazard_sat_counter #(.PERF_W(PERF_W)) u_perf_br (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (br_stall),
      .count (perf_br_o)
   );

   hazard_sat_counter #(.PERF_W(PERF_W)) u_perf_md (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (md_stall),
      .count (perf_md_o)
   );
`else
   assign perf_lw_o = '0;
   assign perf_br_o = '0;
   assign perf_md_o = '0;
`endif

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table plus mul/div, reset and perf sequences.
module tb_hazard_scoreboard;

   localparam int PERF_W = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [4:0]        rs_d_i, rt_d_i, rs_e_i, rt_e_i, write_reg_e_i, write_reg_m_i, write_reg_w_i;
   logic              branch_d_i, md_start_d_i, md_read_d_i;
   logic              mem_to_reg_e_i, reg_write_e_i, md_start_e_i;
   logic              mem_to_reg_m_i, reg_write_m_i, reg_write_w_i;
   logic              stall_f_o, stall_d_o, flush_e_o;
   logic              forward_a_d_o, forward_b_d_o;
   logic [1:0]        forward_a_e_o, forward_b_e_o;
   logic              md_busy_o;
   logic [PERF_W-1:0] perf_lw_o, perf_br_o, perf_md_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   hazard_scoreboard #(.REG_W(5), .MD_LATENCY(4), .PERF_W(PERF_W)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .rs_d_i         (rs_d_i),
      .rt_d_i         (rt_d_i),
      .branch_d_i     (branch_d_i),
      .md_start_d_i   (md_start_d_i),
      .md_read_d_i    (md_read_d_i),
      .rs_e_i         (rs_e_i),
      .rt_e_i         (rt_e_i),
      .write_reg_e_i  (write_reg_e_i),
      .mem_to_reg_e_i (mem_to_reg_e_i),
      .reg_write_e_i  (reg_write_e_i),
      .md_start_e_i   (md_start_e_i),
      .write_reg_m_i  (write_reg_m_i),
      .mem_to_reg_m_i (mem_to_reg_m_i),
      .reg_write_m_i  (reg_write_m_i),
      .write_reg_w_i  (write_reg_w_i),
      .reg_write_w_i  (reg_write_w_i),
      .stall_f_o      (stall_f_o),
      .stall_d_o      (stall_d_o),
      .flush_e_o      (flush_e_o),
      .forward_a_d_o  (forward_a_d_o),
      .forward_b_d_o  (forward_b_d_o),
      .forward_a_e_o  (forward_a_e_o),
      .forward_b_e_o  (forward_b_e_o),
      .md_busy_o      (md_busy_o),
      .perf_lw_o      (perf_lw_o),
      .perf_br_o      (perf_br_o),
      .perf_md_o      (perf_md_o)
   );

   typedef struct {
      logic [4:0] rs_d, rt_d;
      logic       br, mds, mdr;
      logic [4:0] rs_e, rt_e, wr_e;
      logic       mtr_e, rw_e;
      logic [4:0] wr_m;
      logic       mtr_m, rw_m;
      logic [4:0] wr_w;
      logic       rw_w;
      logic       stall, fad, fbd;
      logic [1:0] fae, fbe;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      rs_d_i = '0; rt_d_i = '0; rs_e_i = '0; rt_e_i = '0;
      write_reg_e_i = '0; write_reg_m_i = '0; write_reg_w_i = '0;
      branch_d_i = 1'b0; md_start_d_i = 1'b0; md_read_d_i = 1'b0;
      mem_to_reg_e_i = 1'b0; reg_write_e_i = 1'b0; md_start_e_i = 1'b0;
      mem_to_reg_m_i = 1'b0; reg_write_m_i = 1'b0; reg_write_w_i = 1'b0;
   endtask

   task automatic check_stall(input string name, input logic exp);
      check({name, " stall_f"}, 32'(stall_f_o), 32'(exp));
      check({name, " stall_d"}, 32'(stall_d_o), 32'(exp));
      check({name, " flush_e"}, 32'(flush_e_o), 32'(exp));
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      //          rs_d   rt_d   br    mds   mdr   rs_e   rt_e   wr_e   mtr_e rw_e  wr_m   mtr_m rw_m  wr_w   rw_w  stall fad   fbd   fae    fbe
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[4]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
      vecs[5]  = '{5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[6]  = '{5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[7]  = '{5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[8]  = '{5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[9]  = '{5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
      vecs[10] = '{5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
      vecs[11] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[12] = '{5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[13] = '{5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10};
      vecs[14] = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[15] = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 5'd2, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};

      clear_inputs();
      rst_ni = 1'b0;
      #12;
      check("reset md_busy", 32'(md_busy_o), 32'd0);
      check_stall("reset", 1'b0);
      check("reset fwd_a_e", 32'(forward_a_e_o), 32'd0);
      check("reset perf_lw", 32'(perf_lw_o), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(posedge clk_i); #1;
         rs_d_i = vecs[i].rs_d;  rt_d_i = vecs[i].rt_d;
         branch_d_i = vecs[i].br; md_start_d_i = vecs[i].mds; md_read_d_i = vecs[i].mdr;
         rs_e_i = vecs[i].rs_e;  rt_e_i = vecs[i].rt_e;  write_reg_e_i = vecs[i].wr_e;
         mem_to_reg_e_i = vecs[i].mtr_e; reg_write_e_i = vecs[i].rw_e;
         write_reg_m_i = vecs[i].wr_m; mem_to_reg_m_i = vecs[i].mtr_m; reg_write_m_i = vecs[i].rw_m;
         write_reg_w_i = vecs[i].wr_w; reg_write_w_i = vecs[i].rw_w;
         @(negedge clk_i);
         check_stall($sformatf("vec%0d", i), vecs[i].stall);
         check($sformatf("vec%0d fwd_a_d", i), 32'(forward_a_d_o), 32'(vecs[i].fad));
         check($sformatf("vec%0d fwd_b_d", i), 32'(forward_b_d_o), 32'(vecs[i].fbd));
         check($sformatf("vec%0d fwd_a_e", i), 32'(forward_a_e_o), 32'(vecs[i].fae));
         check($sformatf("vec%0d fwd_b_e", i), 32'(forward_b_e_o), 32'(vecs[i].fbe));
      end

      // Mul/div issue at cycle 0 with mfhi waiting in D: stall cycles 0..4, busy 1..4.
      do_reset();
      clear_inputs();
      md_read_d_i  = 1'b1;
      md_start_e_i = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk_i);
         check_stall($sformatf("md cyc%0d", c), (c <= 4) ? 1'b1 : 1'b0);
         check($sformatf("md busy cyc%0d", c), 32'(md_busy_o), ((c >= 1) && (c <= 4)) ? 32'd1 : 32'd0);
         @(posedge clk_i); #1;
         md_start_e_i = 1'b0;
      end

      // Reissue mid-countdown reloads the full latency.
      md_read_d_i  = 1'b0;
      md_start_e_i = 1'b1;
      @(posedge clk_i); #1;
      md_start_e_i = 1'b0;
      @(posedge clk_i); #1;
      md_start_e_i = 1'b1;
      @(posedge clk_i); #1;
      md_start_e_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("md reload busy after 3", 32'(md_busy_o), 32'd1);
      @(posedge clk_i); #1;
      check("md reload idle after 4", 32'(md_busy_o), 32'd0);

      // Reset asserted at cycle 2 of a countdown clears busy and stall at once.
      md_read_d_i  = 1'b1;
      md_start_e_i = 1'b1;
      @(posedge clk_i); #1;
      md_start_e_i = 1'b0;
      @(posedge clk_i); #1;
      check("md pre-reset busy", 32'(md_busy_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("md reset busy", 32'(md_busy_o), 32'd0);
      check_stall("md reset", 1'b0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      clear_inputs();

      // Perf counters: 20 cycles of load-use stall saturate a 4-bit counter.
      do_reset();
      rt_d_i = 5'd5; rt_e_i = 5'd5; mem_to_reg_e_i = 1'b1;
      repeat (20) @(posedge clk_i);
      @(negedge clk_i);
`ifdef HAZARD_PERF_EN
      check("perf_lw sat", 32'(perf_lw_o), 32'd15);
`else
      check("perf_lw tied", 32'(perf_lw_o), 32'd0);
`endif
      check("perf_br idle", 32'(perf_br_o), 32'd0);
      check("perf_md idle", 32'(perf_md_o), 32'd0);
      clear_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hazard_scoreboard

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the datapath and driving its stall, flush and forward-select controls. It provides E-stage operand forwarding, D-stage branch-operand forwarding, load-use stalls and branch-dependency stalls, all with register 0 excluded. It also tracks a multi-cycle multiply/divide unit with an internal countdown, stalling D-stage HI/LO consumers until the result is ready. Optional saturating stall counters support performance analysis.

## Interface
- `REG_W`, default 5: register index width.
- `MD_LATENCY`, default 4: mul/div cycles after issue before HI/LO are valid; legal range 1..255.
- `PERF_W`, default 32: performance counter width.

Ports, as name, direction, width, meaning:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `rs_d_i`, `rt_d_i` in REG_W: D-stage source registers.
- `branch_d_i` in 1: D-stage instruction is a branch.
- `md_start_d_i` in 1: D-stage instruction is a mul/div.
- `md_read_d_i` in 1: D-stage instruction is mfhi/mflo.
- `rs_e_i`, `rt_e_i`, `write_reg_e_i` in REG_W: E-stage registers.
- `mem_to_reg_e_i`, `reg_write_e_i`, `md_start_e_i` in 1: E-stage control.
- `write_reg_m_i` in REG_W; `mem_to_reg_m_i`, `reg_write_m_i` in 1: M-stage control.
- `write_reg_w_i` in REG_W; `reg_write_w_i` in 1: W-stage control.
- `stall_f_o`, `stall_d_o`, `flush_e_o` out 1: pipeline control.
- `forward_a_d_o`, `forward_b_d_o` out 1: forward the M-stage result to the D-stage comparator.
- `forward_a_e_o`, `forward_b_e_o` out 2: E-stage operand select.
- `md_busy_o` out 1: the mul/div countdown is nonzero.
- `perf_lw_o`, `perf_br_o`, `perf_md_o` out PERF_W: stall-cycle counts.

## Operation
- **E forwarding**, per operand, with `src` = `rs_e_i` or `rt_e_i`:
  - `src!=0 && src==write_reg_m_i && reg_write_m_i` selects FWD_MEM (2'b10).
  - Otherwise, the same test against the W stage selects FWD_WB (2'b01).
  - Otherwise FWD_NONE (2'b00). M has priority over W.
- **D forwarding**: `forward_a_d_o = rs_d_i!=0 && rs_d_i==write_reg_m_i && reg_write_m_i`. `forward_b_d_o` is the same with `rt_d_i`.
- **lw_stall**: `mem_to_reg_e_i && rt_e_i!=0 && (rs_d_i==rt_e_i || rt_d_i==rt_e_i)`.
- **br_stall**: `branch_d_i` and a nonzero source matching either of:
  - `write_reg_e_i` with `reg_write_e_i`, or
  - `write_reg_m_i` with `mem_to_reg_m_i`.
- **Mul/div countdown** `md_cnt`, width `$clog2(MD_LATENCY+1)`:
  - Loads MD_LATENCY at the edge after any cycle with `md_start_e_i=1`. Load takes priority over decrement.
  - Otherwise decrements by 1 per edge while nonzero, and holds at 0.
- **md_stall**: `(md_read_d_i || md_start_d_i) && (md_cnt!=0 || md_start_e_i)`.
- **Combined stall**: `stall_f_o = stall_d_o = flush_e_o = lw_stall | br_stall | md_stall`.
- `md_busy_o = (md_cnt != 0)`.

## Timing
- All hazard and forward outputs are combinational from the inputs and `md_cnt`. There is no output latency.
- Reset asserted: `md_cnt=0` and all perf counters 0. With all inputs 0, every output is 0.
- Mul/div issue in E at cycle t with a dependent instruction in D at t: stalled for cycles t..t+MD_LATENCY (MD_LATENCY+1 cycles). It proceeds at t+MD_LATENCY+1.
- `md_start_e_i` while `md_cnt!=0` (cannot occur in legal flow): the counter reloads to MD_LATENCY.
- Reset asserted mid-countdown: `md_cnt` clears immediately and stalls from the counter drop in the same cycle.
- Simultaneous stall causes count once each in their own perf counters. Flush never suppresses the current `md_start_e_i`.

## Configuration
- `HAZARD_PERF_EN` defined:
  - Each perf counter increments by 1 per clock in which its stall cause is active.
  - Counters saturate at all-ones.
- `HAZARD_PERF_EN` undefined:
  - Ports remain present and are tied to 0.
  - No counter flops are built.

## Structure
- Package `hazard_pkg`:
  - `fwd_sel_e` enum: FWD_NONE, FWD_WB, FWD_MEM.
  - `reg_idx_t` typedef (logic [4:0]).
- Sub-module `hazard_sat_counter`, parameterised by PERF_W:
  - Ports: clk, rst_n, inc, count.
  - Instantiated three times, only under `HAZARD_PERF_EN`.

## Test plan
- **E forwarding**: `rs_e_i=3`, `write_reg_m_i=3`, `reg_write_m_i=1`, `write_reg_w_i=3`, `reg_write_w_i=1` → `forward_a_e_o=2'b10`. Drop `reg_write_m_i` → `2'b01`. With `rs_e_i=0` → `2'b00`.
- **Load-use**: `mem_to_reg_e_i=1`, `rt_e_i=5`, `rt_d_i=5` → stall/flush=1. With `rt_e_i=0` → 0.
- **Branch stall**: `branch_d_i=1`, `rs_d_i=7`, `reg_write_e_i=1`, `write_reg_e_i=7` → stall=1. Next, with E cleared and `write_reg_m_i=7`, `reg_write_m_i=1`, `mem_to_reg_m_i=0` → stall=0 and `forward_a_d_o=1`.
- **Mul/div dependency**: MD_LATENCY=4. Pulse `md_start_e_i` at cycle 0 with `md_read_d_i` held high → stall high for cycles 0–4, low at 5. `md_busy_o` high for cycles 1–4.
- **Reset mid-operation**: drop `rst_ni` at cycle 2 of a countdown → `md_busy_o=0` and stall=0 immediately.
- **Perf counters**: with `HAZARD_PERF_EN` and PERF_W=4, hold lw_stall for 20 cycles → `perf_lw_o=15`. Without the macro → all perf outputs stay 0.
